// File: rtl/button_event_pkg.sv
// Shared state encodings and default cycle constants for the button event block
// and the game controller that consumes its events.
package button_event_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PRESS    = 2'd2,
        ST_LONG     = 2'd3
    } state_t;

    localparam int DEFAULT_LONG_CYCLES   = 50_000_000;
    localparam int DEFAULT_REPEAT_CYCLES = 10_000_000;
    localparam int DEFAULT_CNT_W         = 27;
    localparam int PRESS_COUNT_W         = 8;

    function automatic logic is_held(input state_t s);
        return (s == ST_PRESS) || (s == ST_LONG);
    endfunction

endpackage

// File: rtl/button_event_if.sv
// Debounced button level in, one-cycle button events out.
// master = event generator, slave = consumer (game control FSM).
interface button_event_if;
    import button_event_pkg::*;

    logic                     btn_in;
    logic                     press_pulse;
    logic                     release_pulse;
    logic                     long_pulse;
    logic                     repeat_pulse;
    logic                     held;
    logic                     was_long;
    logic [PRESS_COUNT_W-1:0] press_count;

    modport master (
        input  btn_in,
        output press_pulse, release_pulse, long_pulse, repeat_pulse,
        output held, was_long, press_count
    );

    modport slave (
        output btn_in,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse,
        input  held, was_long, press_count
    );

endinterface

// File: rtl/button_event_cycle_timer.sv
// Clear/enable cycle counter with a terminal-count compare; clear has priority.
module button_event_cycle_timer #(
    parameter int CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] terminal,
    output logic             at_terminal
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign at_terminal = (count_reg == terminal);

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into registered one-cycle press/release/long/repeat
// events plus a press counter. Auto-repeat is built only with BUTTON_AUTO_REPEAT_EN.
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    button_event_if.master  evt
);

    localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);

    state_t                   state_reg, state_next;
    logic                     press_reg, press_next;
    logic                     release_reg, release_next;
    logic                     long_reg, long_next;
    logic                     repeat_reg, repeat_next;
    logic                     held_reg, held_next;
    logic                     was_long_reg, was_long_next;
    logic [PRESS_COUNT_W-1:0] count_reg, count_next;

    logic             btn;
    logic             at_terminal;
    logic             repeat_fire;
    logic             timer_clear;
    logic [CNT_W-1:0] terminal;

    assign btn      = evt.btn_in;
    assign terminal = (state_reg == ST_LONG) ? REPEAT_TC : LONG_TC;

`ifdef BUTTON_AUTO_REPEAT_EN
    assign repeat_fire = (state_reg == ST_LONG) && btn && at_terminal;
    assign timer_clear = (state_next != state_reg) || !is_held(state_reg) || repeat_fire;
`else
    assign repeat_fire = 1'b0;
    // Without auto-repeat the LONG timer is parked at zero.
    assign timer_clear = (state_next != state_reg) || (state_reg != ST_PRESS);
`endif

    button_event_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (timer_clear),
        .enable      (!timer_clear),
        .terminal    (terminal),
        .at_terminal (at_terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_WAIT_LOW;
            press_reg    <= 1'b0;
            release_reg  <= 1'b0;
            long_reg     <= 1'b0;
            repeat_reg   <= 1'b0;
            held_reg     <= 1'b0;
            was_long_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            press_reg    <= press_next;
            release_reg  <= release_next;
            long_reg     <= long_next;
            repeat_reg   <= repeat_next;
            held_reg     <= held_next;
            was_long_reg <= was_long_next;
            count_reg    <= count_next;
        end
    end

    // A level already high out of reset must drop before a press can be accepted.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_WAIT_LOW: if (!btn) state_next = ST_IDLE;
            ST_IDLE:     if (btn)  state_next = ST_PRESS;
            ST_PRESS: begin
                if (!btn)             state_next = ST_IDLE;
                else if (at_terminal) state_next = ST_LONG;
            end
            ST_LONG:     if (!btn) state_next = ST_IDLE;
            default:     state_next = ST_WAIT_LOW;
        endcase
    end

    // Release is checked first in every held state, so it beats long/repeat on the same edge.
    always_comb begin
        press_next    = (state_reg == ST_IDLE) && btn;
        release_next  = is_held(state_reg) && !btn;
        long_next     = (state_reg == ST_PRESS) && btn && at_terminal;
        repeat_next   = repeat_fire;
        held_next     = is_held(state_next);
        count_next    = count_reg + PRESS_COUNT_W'(press_next || repeat_fire);
        was_long_next = was_long_reg;
        if (press_next) begin
            was_long_next = 1'b0;
        end else if ((state_reg == ST_LONG) && !btn) begin
            was_long_next = 1'b1;
        end
    end

    assign evt.press_pulse   = press_reg;
    assign evt.release_pulse = release_reg;
    assign evt.long_pulse    = long_reg;
    assign evt.repeat_pulse  = repeat_reg;
    assign evt.held          = held_reg;
    assign evt.was_long      = was_long_reg;
    assign evt.press_count   = count_reg;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4; follows
// BUTTON_AUTO_REPEAT_EN for the repeat expectations.
module tb_button_event;

    localparam int LONG_C = 8;
    localparam int REP_C  = 4;
`ifdef BUTTON_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_event_if bif ();

    button_event #(
        .LONG_CYCLES   (LONG_C),
        .REPEAT_CYCLES (REP_C),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (bif)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_count   = 8'd0;

    // {press, release, long, repeat, held}
    function automatic logic [4:0] ev();
        return {bif.press_pulse, bif.release_pulse, bif.long_pulse,
                bif.repeat_pulse, bif.held};
    endfunction

    task automatic step(input logic b);
        @(negedge clk);
        bif.btn_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        rst_n = 1'b0;
        bif.btn_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({ev(), bif.was_long, bif.press_count} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected %b", {ev(), bif.was_long, bif.press_count}, 14'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            vectors++;
            if (ev() !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_held_level i=%0d: got %b expected %b", i, ev(), 5'b00000);
            end
        end
        for (int i = 0; i < 5; i++) begin
            logic b;
            b = (i == 2 || i == 3);
            step(b);
            exp = (i == 2) ? 5'b10001 : (i == 3) ? 5'b00001 : (i == 4) ? 5'b01000 : 5'b00000;
            vectors++;
            if (ev() !== exp) begin
                miscompares++;
                $display("FAIL reset_first_press i=%0d: got %b expected %b", i, ev(), exp);
            end
        end
        exp_count = 8'd1;
        vectors++;
        if (bif.press_count !== exp_count) begin
            miscompares++;
            $display("FAIL reset_first_count: got %0d expected %0d", bif.press_count, exp_count);
        end
    endtask

    task automatic test_short_press();
        logic [4:0] exp;
        for (int i = 0; i < 5; i++) begin
            step(i < 3);
            exp = {(i == 0), (i == 3), 1'b0, 1'b0, (i < 3)};
            vectors++;
            if (ev() !== exp) begin
                miscompares++;
                $display("FAIL short_press i=%0d: got %b expected %b", i, ev(), exp);
            end
        end
        exp_count = exp_count + 8'd1;
        vectors++;
        if ({bif.was_long, bif.press_count} !== {1'b0, exp_count}) begin
            miscompares++;
            $display("FAIL short_press_end: got %b/%0d expected 0/%0d", bif.was_long, bif.press_count, exp_count);
        end
    endtask

    task automatic test_long_hold();
        logic [4:0] exp;
        logic       rep;
        for (int i = 0; i < 23; i++) begin
            step(i < 21);
            rep = AR && (i == 12 || i == 16 || i == 20);
            exp = {(i == 0), (i == 21), (i == 8), rep, (i < 21)};
            vectors++;
            if (ev() !== exp) begin
                miscompares++;
                $display("FAIL long_hold i=%0d: got %b expected %b", i, ev(), exp);
            end
        end
        exp_count = exp_count + (AR ? 8'd4 : 8'd1);
        vectors++;
        if ({bif.was_long, bif.press_count} !== {1'b1, exp_count}) begin
            miscompares++;
            $display("FAIL long_hold_end: got %b/%0d expected 1/%0d", bif.was_long, bif.press_count, exp_count);
        end
    endtask

    task automatic test_long_boundary();
        logic [4:0] exp;
        for (int i = 0; i < 10; i++) begin
            step(i < LONG_C);
            exp = {(i == 0), (i == LONG_C), 1'b0, 1'b0, (i < LONG_C)};
            vectors++;
            if (ev() !== exp) begin
                miscompares++;
                $display("FAIL long_boundary i=%0d: got %b expected %b", i, ev(), exp);
            end
        end
        exp_count = exp_count + 8'd1;
        vectors++;
        if ({bif.was_long, bif.press_count} !== {1'b0, exp_count}) begin
            miscompares++;
            $display("FAIL long_boundary_end: got %b/%0d expected 0/%0d", bif.was_long, bif.press_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        for (int i = 0; i < 5; i++) begin
            step(i == 0 || i == 2);
            exp = {(i == 0 || i == 2), (i == 1 || i == 3), 1'b0, 1'b0, (i == 0 || i == 2)};
            vectors++;
            if (ev() !== exp) begin
                miscompares++;
                $display("FAIL back_to_back i=%0d: got %b expected %b", i, ev(), exp);
            end
        end
        exp_count = exp_count + 8'd2;
        vectors++;
        if (bif.press_count !== exp_count) begin
            miscompares++;
            $display("FAIL back_to_back_count: got %0d expected %0d", bif.press_count, exp_count);
        end
    endtask

    task automatic test_reset_in_long();
        for (int i = 0; i <= LONG_C; i++) step(1'b1);
        vectors++;
        if (ev() !== 5'b00101) begin
            miscompares++;
            $display("FAIL reset_in_long_pre: got %b expected %b", ev(), 5'b00101);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_count = 8'd0;
        vectors++;
        if ({ev(), bif.was_long, bif.press_count} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_in_long_async: got %b expected %b", {ev(), bif.was_long, bif.press_count}, 14'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(i < 5);
            vectors++;
            if (ev() !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_in_long_after i=%0d: got %b expected %b", i, ev(), 5'b00000);
            end
        end
    endtask

    task automatic test_count_wrap();
        for (int n = 0; n < 256; n++) begin
            step(1'b1);
            step(1'b0);
        end
        vectors++;
        if (bif.press_count !== 8'd0) begin
            miscompares++;
            $display("FAIL count_wrap_256: got %0d expected %0d", bif.press_count, 0);
        end
        step(1'b1);
        vectors++;
        if ({bif.press_pulse, bif.press_count} !== {1'b1, 8'd1}) begin
            miscompares++;
            $display("FAIL count_wrap_257: got %b/%0d expected 1/1", bif.press_pulse, bif.press_count);
        end
        step(1'b0);
    endtask

    initial begin
        bif.btn_in = 1'b1;
        test_reset();
        test_short_press();
        test_long_hold();
        test_long_boundary();
        test_back_to_back();
        test_reset_in_long();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
